// File: rtl/led_matrix_decoder.sv
// Captures a time-multiplexed RGB pixel stream into a 16x8 back buffer per window
// and scans the front buffer out row by row. Optional LED_MATRIX_DECODER_STABLE_FILTER_EN.
module led_matrix_decoder #(
  parameter int FRAME_CYCLES = 262144,
  parameter int ROW_DWELL    = 2000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [9:0] PIX_IN,
  output logic [3:0] ROW_SEL,
  output logic       ROW_EN,
  output logic [7:0] COL_R,
  output logic [7:0] COL_G,
  output logic [7:0] COL_B,
  output logic       FRAME_TICK,
  output logic [7:0] PIX_CNT
);

  localparam logic [19:0] WIN_LAST   = 20'(FRAME_CYCLES - 1);
  localparam logic [11:0] DWELL_LAST = 12'(ROW_DWELL - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  logic [9:0]             s1_q, s1_d;
  logic                   accept;
  logic                   wr_en;
  logic [3:0]             wr_row;
  logic [2:0]             wr_col;
  logic [2:0]             wr_rgb;
  logic                   wrap;
  logic [19:0]            win_q, win_d;
  logic [15:0][7:0][2:0]  back_q, back_d;
  logic [15:0][7:0][2:0]  front_q, front_d;
  logic [7:0]             back_cnt_q, back_cnt_d;
  logic [7:0]             pix_cnt_q, pix_cnt_d;
  logic                   tick_q, tick_d;
  state_t                 state_q, state_d;
  logic [3:0]             row_q, row_d;
  logic [11:0]            dwell_q, dwell_d;
  logic                   en_q, en_d;
  logic [7:0]             col_r_q, col_r_d;
  logic [7:0]             col_g_q, col_g_d;
  logic [7:0]             col_b_q, col_b_d;

`ifdef LED_MATRIX_DECODER_STABLE_FILTER_EN
  logic [9:0] s2_q, s2_d;

  always_comb begin
    s2_d   = s1_q;
    accept = (s1_q == s2_q);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) s2_q <= '0;
    else       s2_q <= s2_d;
  end
`else
  always_comb accept = 1'b1;
`endif

  always_comb begin
    s1_d   = PIX_IN;
    wr_rgb = s1_q[9:7];
    wr_row = s1_q[6:3];
    wr_col = s1_q[2:0];
    wr_en  = accept && (wr_rgb != 3'b000);
    wrap   = (win_q == WIN_LAST);
    win_d  = wrap ? '0 : win_q + 20'd1;
  end

  // Swap happens first so a write in the wrap cycle lands in the freshly cleared buffer.
  always_comb begin
    front_d    = front_q;
    pix_cnt_d  = pix_cnt_q;
    back_d     = back_q;
    back_cnt_d = back_cnt_q;
    tick_d     = wrap;
    if (wrap) begin
      front_d    = back_q;
      pix_cnt_d  = back_cnt_q;
      back_d     = '0;
      back_cnt_d = '0;
    end
    if (wr_en) begin
      if (back_d[wr_row][wr_col] == 3'b000 && back_cnt_d != 8'd128)
        back_cnt_d = back_cnt_d + 8'd1;
      back_d[wr_row][wr_col] = back_d[wr_row][wr_col] | wr_rgb;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    case (state_q)
      BLANK: begin
        state_d = SHOW;
        dwell_d = '0;
      end
      SHOW: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = BLANK;
          row_d   = row_q + 4'd1;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + 12'd1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Drive registers are loaded from next-state values so they line up with ROW_SEL.
  always_comb begin
    en_d    = (state_d == SHOW);
    col_r_d = '0;
    col_g_d = '0;
    col_b_d = '0;
    if (en_d) begin
      for (int x = 0; x < 8; x++) begin
        col_r_d[x] = front_d[row_d][x][2];
        col_g_d[x] = front_d[row_d][x][1];
        col_b_d[x] = front_d[row_d][x][0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1_q       <= '0;
      win_q      <= '0;
      back_q     <= '0;
      front_q    <= '0;
      back_cnt_q <= '0;
      pix_cnt_q  <= '0;
      tick_q     <= 1'b0;
      state_q    <= BLANK;
      row_q      <= '0;
      dwell_q    <= '0;
      en_q       <= 1'b0;
      col_r_q    <= '0;
      col_g_q    <= '0;
      col_b_q    <= '0;
    end else begin
      s1_q       <= s1_d;
      win_q      <= win_d;
      back_q     <= back_d;
      front_q    <= front_d;
      back_cnt_q <= back_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      tick_q     <= tick_d;
      state_q    <= state_d;
      row_q      <= row_d;
      dwell_q    <= dwell_d;
      en_q       <= en_d;
      col_r_q    <= col_r_d;
      col_g_q    <= col_g_d;
      col_b_q    <= col_b_d;
    end
  end

  assign ROW_SEL    = row_q;
  assign ROW_EN     = en_q;
  assign COL_R      = col_r_q;
  assign COL_G      = col_g_q;
  assign COL_B      = col_b_q;
  assign FRAME_TICK = tick_q;
  assign PIX_CNT    = pix_cnt_q;

endmodule

// File: tb/tb_led_matrix_decoder.sv
// Bench for led_matrix_decoder: directed steps plus random words, checked every cycle
// against a window/scan model built from a write log.
module tb_led_matrix_decoder;

  localparam int F    = 64;
  localparam int D    = 3;
  localparam int SCAN = 16 * (D + 1);
`ifdef LED_MATRIX_DECODER_STABLE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  localparam logic [9:0] W29 = 10'b1001100010;
  localparam logic [9:0] W30 = 10'b0101100010;
  localparam logic [9:0] W31 = 10'b0010000111;
  localparam logic [9:0] W33 = {3'b100, 4'd9, 3'd3};

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [9:0] PIX_IN = '0;
  logic [3:0] ROW_SEL;
  logic       ROW_EN;
  logic [7:0] COL_R, COL_G, COL_B;
  logic       FRAME_TICK;
  logic [7:0] PIX_CNT;

  led_matrix_decoder #(.FRAME_CYCLES(F), .ROW_DWELL(D)) dut (
    .CLK(CLK), .RSTn(RSTn), .PIX_IN(PIX_IN), .ROW_SEL(ROW_SEL), .ROW_EN(ROW_EN),
    .COL_R(COL_R), .COL_G(COL_G), .COL_B(COL_B), .FRAME_TICK(FRAME_TICK), .PIX_CNT(PIX_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {int e; int r; int c; logic [2:0] rgb;} wr_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         k = 0;
  bit         fresh = 1'b0;
  logic [9:0] hist[$];
  wr_t        log_q[$];
  logic [2:0] mfront[16][8];
  int         mcnt = 0;
  logic [9:0] rprev = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): got %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic clear_front();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) mfront[r][c] = 3'b000;
    mcnt = 0;
  endtask

  // Front shown from cycle (m+1)*F holds every write landing on edges m*F .. m*F+F-1.
  task automatic rebuild_front(input int m);
    while (log_q.size() > 0 && log_q[0].e / F < m) void'(log_q.pop_front());
    clear_front();
    foreach (log_q[i])
      if (log_q[i].e / F == m) mfront[log_q[i].r][log_q[i].c] |= log_q[i].rgb;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) if (mfront[r][c] != 3'b000) mcnt++;
  endtask

  task automatic check_outputs();
    int p, row;
    logic en;
    logic [7:0] er, eg, eb;
    p   = k % SCAN;
    row = p / (D + 1);
    en  = (p % (D + 1)) != 0;
    er = '0; eg = '0; eb = '0;
    if (en)
      for (int c = 0; c < 8; c++) begin
        er[c] = mfront[row][c][2];
        eg[c] = mfront[row][c][1];
        eb[c] = mfront[row][c][0];
      end
    chk("row_sel", ROW_SEL, row);
    chk("row_en", ROW_EN, en);
    chk("col_r", COL_R, er);
    chk("col_g", COL_G, eg);
    chk("col_b", COL_B, eb);
    chk("frame_tick", FRAME_TICK, (k > 0 && k % F == 0));
    chk("pix_cnt", PIX_CNT, mcnt);
  endtask

  // One cycle: check outputs for cycle k, then drive the word sampled at the end of it.
  task automatic tick_cycle(input logic [9:0] w);
    logic [9:0] wd, prv;
    wr_t t;
    if (fresh) fresh = 1'b0;
    else @(negedge CLK);
    if (k > 0 && k % F == 0) rebuild_front(k / F - 1);
    check_outputs();
    PIX_IN = w;
    hist.push_back(w);
    if (k >= 1) begin
      wd  = hist[k-1];
      prv = (k >= 2) ? hist[k-2] : 10'd0;
      if (wd[9:7] != 3'b000 && (!FILT || prv == wd)) begin
        t.e = k + 1; t.r = int'(wd[6:3]); t.c = int'(wd[2:0]); t.rgb = wd[9:7];
        log_q.push_back(t);
      end
    end
    k++;
  endtask

  task automatic run_to(input int target, input logic [9:0] w);
    while (k <= target) tick_cycle(w);
  endtask

  function automatic logic [9:0] rand_word();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4)      rand_word = rprev;
    else if (r < 6) rand_word = '0;
    else            rand_word = 10'($urandom_range(0, 1023));
    rprev = rand_word;
  endfunction

  task automatic run_rand_to(input int target);
    while (k <= target) tick_cycle(rand_word());
  endtask

  task automatic do_reset();
    RSTn   = 1'b0;
    PIX_IN = '0;
    repeat (3) @(negedge CLK);
    chk("rst_row_en", ROW_EN, 0);
    chk("rst_row_sel", ROW_SEL, 0);
    chk("rst_cols", {COL_R, COL_G, COL_B}, 0);
    chk("rst_tick", FRAME_TICK, 0);
    chk("rst_pix_cnt", PIX_CNT, 0);
    RSTn = 1'b1;
    k = 0;
    hist.delete();
    log_q.delete();
    clear_front();
    fresh = 1'b1;
  endtask

  initial begin
    // all-idle windows
    do_reset();
    run_to(F, 10'd0);
    chk("idle_tick", FRAME_TICK, 1);
    chk("idle_cnt", PIX_CNT, 0);
    run_to(2 * F + 1, 10'd0);

    // single held pixel: red, row 12, column 2
    do_reset();
    while (k <= F - 3) tick_cycle(W29);
    run_to(F + 49, 10'd0);
    chk("r12_sel", ROW_SEL, 12);
    chk("r12_en", ROW_EN, 1);
    chk("r12_r", COL_R, 8'h04);
    chk("r12_g", COL_G, 8'h00);
    chk("r12_b", COL_B, 8'h00);
    chk("r12_cnt", PIX_CNT, 1);

    // red then green on the same pixel merge
    repeat (4) tick_cycle(W29);
    repeat (4) tick_cycle(W30);
    run_to(2 * F + 49, 10'd0);
    chk("merge_r", COL_R, 8'h04);
    chk("merge_g", COL_G, 8'h04);
    chk("merge_cnt", PIX_CNT, 1);

    // single-cycle glitch, then a two-cycle word
    run_to(2 * F + 51, 10'd0);
    tick_cycle(W31);
    run_to(3 * F + 1, 10'd0);
    chk("glitch_cnt", PIX_CNT, FILT ? 0 : 1);
    chk("glitch_b", COL_B, FILT ? 8'h00 : 8'h80);
    run_to(3 * F + 7, 10'd0);
    repeat (2) tick_cycle(W31);
    run_to(4 * F + 1, 10'd0);
    chk("held2_cnt", PIX_CNT, 1);
    chk("held2_b", COL_B, 8'h80);

    // write landing exactly on the wrap edge goes to the next window
    run_to(5 * F - 4, 10'd0);
    tick_cycle(FILT ? W29 : 10'd0);
    tick_cycle(W29);
    run_to(5 * F, 10'd0);
    chk("wrapwr_tick", FRAME_TICK, 1);
    chk("wrapwr_cnt0", PIX_CNT, 0);
    run_to(6 * F, 10'd0);
    chk("wrapwr_cnt1", PIX_CNT, 1);

    // random traffic, with a known pixel in row 9 of the last window
    run_rand_to(8 * F - 1);
    repeat (4) tick_cycle(W33);
    run_rand_to(9 * F - 1);
    for (int i = 0; i < SCAN && ((k - 1) % SCAN) != 9 * (D + 1) + 2; i++) tick_cycle(10'd0);
    chk("pre_rst_sel", ROW_SEL, 9);
    chk("pre_rst_r3", COL_R[3], 1);

    // asynchronous reset in the middle of row 9
    RSTn = 1'b0;
    #1;
    chk("arst_en", ROW_EN, 0);
    chk("arst_cols", {COL_R, COL_G, COL_B}, 0);
    chk("arst_sel", ROW_SEL, 0);
    do_reset();
    run_to(0, 10'd0);
    chk("post_blank_en", ROW_EN, 0);
    run_to(1, 10'd0);
    chk("post_show_en", ROW_EN, 1);
    chk("post_show_sel", ROW_SEL, 0);
    run_to(D + 1, 10'd0);
    chk("post_blank1_en", ROW_EN, 0);
    chk("post_blank1_sel", ROW_SEL, 1);
    run_rand_to(4 * F + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
